// File: rtl/seg_scan_driver_pkg.sv
// rtl/seg_scan_driver_pkg.sv - shared segment constants for the seven-segment scan driver
// Segment patterns are {a,b,c,d,e,f,g}, active low.
package seg_scan_driver_pkg;

    localparam logic [6:0] HEX7_0 = 7'b0000001;
    localparam logic [6:0] HEX7_1 = 7'b1001111;
    localparam logic [6:0] HEX7_2 = 7'b0010010;
    localparam logic [6:0] HEX7_3 = 7'b0000110;
    localparam logic [6:0] HEX7_4 = 7'b1001100;
    localparam logic [6:0] HEX7_5 = 7'b0100100;
    localparam logic [6:0] HEX7_6 = 7'b0100000;
    localparam logic [6:0] HEX7_7 = 7'b0001111;
    localparam logic [6:0] HEX7_8 = 7'b0000000;
    localparam logic [6:0] HEX7_9 = 7'b0000100;
    localparam logic [6:0] HEX7_A = 7'b0001000;
    localparam logic [6:0] HEX7_B = 7'b1100000;
    localparam logic [6:0] HEX7_C = 7'b0110001;
    localparam logic [6:0] HEX7_D = 7'b1000010;
    localparam logic [6:0] HEX7_E = 7'b0110000;
    localparam logic [6:0] HEX7_F = 7'b0111000;

    localparam logic [6:0] SEG7_OFF = 7'h7F;
    localparam logic [7:0] SEG_OFF  = 8'hFF;

    localparam int SEG_A_BIT  = 7;
    localparam int SEG_B_BIT  = 6;
    localparam int SEG_C_BIT  = 5;
    localparam int SEG_D_BIT  = 4;
    localparam int SEG_E_BIT  = 3;
    localparam int SEG_F_BIT  = 2;
    localparam int SEG_G_BIT  = 1;
    localparam int SEG_DP_BIT = 0;

endpackage

// File: rtl/seg_scan_driver_hex_decode.sv
// rtl/seg_scan_driver_hex_decode.sv - combinational hex nibble to active-low a..g decoder
module seg_hex_decode
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG7_OFF;
        case (nib_i)
            4'h0: seg_o = HEX7_0;
            4'h1: seg_o = HEX7_1;
            4'h2: seg_o = HEX7_2;
            4'h3: seg_o = HEX7_3;
            4'h4: seg_o = HEX7_4;
            4'h5: seg_o = HEX7_5;
            4'h6: seg_o = HEX7_6;
            4'h7: seg_o = HEX7_7;
            4'h8: seg_o = HEX7_8;
            4'h9: seg_o = HEX7_9;
            4'hA: seg_o = HEX7_A;
            4'hB: seg_o = HEX7_B;
            4'hC: seg_o = HEX7_C;
            4'hD: seg_o = HEX7_D;
            4'hE: seg_o = HEX7_E;
            4'hF: seg_o = HEX7_F;
            default: seg_o = SEG7_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - time-multiplexed seven-segment scan driver with tear-free updates
// Optional leading-zero suppression: SEG_LZ_SUPPRESS_EN.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 1000,
    parameter int BLANK_CYC  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    input  logic [4*NUM_DIGITS-1:0] upd_value,
    input  logic [NUM_DIGITS-1:0]   upd_dp,
    input  logic [NUM_DIGITS-1:0]   upd_blank,
    output logic [7:0]              seg_n,
    output logic [NUM_DIGITS-1:0]   dig_n
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = ($clog2(NUM_DIGITS) > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d, act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
    logic                    tick, frame_end;
    logic [3:0]              cur_nib;
    logic [6:0]              hex_seg, lit_seg;

    assign tick      = (cnt_q == CW'(CLK_DIV - 1));
    assign frame_end = tick && (idx_q == IW'(NUM_DIGITS - 1));
    assign upd_ready = !pending_q;

`ifdef SEG_LZ_SUPPRESS_EN
    logic [NUM_DIGITS-1:0] lz_q, lz_d, lz_calc;
    logic                  lz_seen;

    // A digit is suppressed when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        lz_calc = '0;
        lz_seen = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (pend_val_q[4*i +: 4] != 4'h0) lz_seen = 1'b1;
            lz_calc[i] = !lz_seen;
        end
    end
`endif

    always_comb begin
        cnt_d        = tick ? '0 : cnt_q + CW'(1);
        idx_d        = idx_q;
        pending_d    = pending_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        act_val_d    = act_val_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
`ifdef SEG_LZ_SUPPRESS_EN
        lz_d         = lz_q;
`endif
        if (tick) idx_d = frame_end ? '0 : idx_q + IW'(1);
        // Transfer needs pending set and capture needs it clear, so the two never collide.
        if (frame_end && pending_q) begin
            act_val_d   = pend_val_q;
            act_dp_d    = pend_dp_q;
            act_blank_d = pend_blank_q;
            pending_d   = 1'b0;
`ifdef SEG_LZ_SUPPRESS_EN
            lz_d        = lz_calc;
`endif
        end else if (upd_valid && !pending_q) begin
            pend_val_d   = upd_value;
            pend_dp_d    = upd_dp;
            pend_blank_d = upd_blank;
            pending_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '1;
            act_val_q    <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '1;
`ifdef SEG_LZ_SUPPRESS_EN
            lz_q         <= '0;
`endif
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
`ifdef SEG_LZ_SUPPRESS_EN
            lz_q         <= lz_d;
`endif
        end
    end

    assign cur_nib = act_val_q[4*int'(idx_q) +: 4];

    seg_hex_decode u_hex (
        .nib_i (cur_nib),
        .seg_o (hex_seg)
    );

`ifdef SEG_LZ_SUPPRESS_EN
    assign lit_seg = lz_q[idx_q] ? SEG7_OFF : hex_seg;
`else
    assign lit_seg = hex_seg;
`endif

    always_comb begin
        seg_n = SEG_OFF;
        dig_n = '1;
        if (int'(cnt_q) >= BLANK_CYC) begin
            dig_n = ~(NUM_DIGITS'(1) << idx_q);
            if (!act_blank_q[idx_q]) seg_n = {lit_seg, ~act_dp_q[idx_q]};
        end
    end

endmodule
